// File: rtl/bittime_counter.sv
// Bit-timing quantum counter: sequences SYNC/TSEG1/TSEG2 per prescaler quantum,
// applies hard sync and SJW-limited resync, and pulses sample point / bit end.
module bittime_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Prescale_EN,
    input  logic [WIDTH-1:0] tseg1,
    input  logic [WIDTH-1:0] tseg2,
    input  logic [WIDTH-1:0] sjw,
    input  logic             hard_sync,
    input  logic             rx_edge,
    output logic [WIDTH-1:0] counto,
    output logic [1:0]       seg,
    output logic             sample_point,
    output logic             bit_end,
    output logic             resync_taken
);

    localparam int unsigned CW = WIDTH + 1;

    typedef enum logic [1:0] {
        SEG_SYNC  = 2'b00,
        SEG_TSEG1 = 2'b01,
        SEG_TSEG2 = 2'b10
    } seg_t;

    seg_t             state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] t1_q;
    logic [WIDTH-1:0] t2_q;
    logic [WIDTH-1:0] sjw_q;
    logic [WIDTH-1:0] ext_q;
    logic [WIDTH-1:0] shrink_q;
    logic             resync_done;

    logic [WIDTH-1:0] t1_fix;
    logic [WIDTH-1:0] t2_fix;
    logic [WIDTH-1:0] sjw_nz;
    logic [WIDTH-1:0] sjw_fix;
    logic [CW-1:0]    cnt_inc;
    logic [CW-1:0]    t1_end;
    logic [CW-1:0]    t2_end;
    logic [CW-1:0]    t2_end_shr;
    logic [CW-1:0]    phase_err;
    logic [WIDTH-1:0] ext_cand;
    logic             resync_ok;
    logic             early_end;
    logic             t2_done;

    // Configuration fix-up and the segment end compares, all in WIDTH+1 bits
    always_comb begin
        t1_fix     = (tseg1 == '0) ? WIDTH'(1) : tseg1;
        t2_fix     = (tseg2 == '0) ? WIDTH'(1) : tseg2;
        sjw_nz     = (sjw == '0) ? WIDTH'(1) : sjw;
        sjw_fix    = (sjw_nz > t2_fix) ? t2_fix : sjw_nz;
        cnt_inc    = cnt + CW'(1);
        t1_end     = CW'(t1_q) + CW'(ext_q) - CW'(1);
        t2_end     = CW'(t2_q) - CW'(1) - CW'(shrink_q);
        t2_end_shr = CW'(t2_q) - CW'(1) - CW'(sjw_q);
        phase_err  = CW'(t2_q) - cnt;
        ext_cand   = (cnt_inc > CW'(sjw_q)) ? sjw_q : cnt_inc[WIDTH-1:0];
        resync_ok  = rx_edge && !resync_done;
        early_end  = phase_err <= CW'(sjw_q);
        // A shrink applied this quantum already moves the end point
        t2_done    = resync_ok ? (cnt == t2_end_shr) : (cnt == t2_end);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= SEG_SYNC;
            cnt          <= '0;
            t1_q         <= WIDTH'(1);
            t2_q         <= WIDTH'(1);
            sjw_q        <= WIDTH'(1);
            ext_q        <= '0;
            shrink_q     <= '0;
            resync_done  <= 1'b0;
            sample_point <= 1'b0;
            bit_end      <= 1'b0;
            resync_taken <= 1'b0;
        end else begin
            sample_point <= 1'b0;
            bit_end      <= 1'b0;
            resync_taken <= 1'b0;
            if (Prescale_EN) begin
                if (hard_sync) begin
                    state       <= SEG_TSEG1;
                    cnt         <= '0;
                    ext_q       <= '0;
                    shrink_q    <= '0;
                    resync_done <= 1'b1;
                    t1_q        <= t1_fix;
                    t2_q        <= t2_fix;
                    sjw_q       <= sjw_fix;
                end else begin
                    case (state)
                        SEG_SYNC: begin
                            state       <= SEG_TSEG1;
                            cnt         <= '0;
                            resync_done <= 1'b0;
                        end
                        SEG_TSEG1: begin
                            if (resync_ok) begin
                                ext_q        <= ext_cand;
                                resync_done  <= 1'b1;
                                resync_taken <= 1'b1;
                                cnt          <= cnt_inc;
                            end else if (cnt == t1_end) begin
                                state        <= SEG_TSEG2;
                                cnt          <= '0;
                                sample_point <= 1'b1;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end
                        SEG_TSEG2: begin
                            if (resync_ok && early_end) begin
                                // Edge quantum acts as SYNC of the next bit
                                state        <= SEG_TSEG1;
                                cnt          <= '0;
                                bit_end      <= 1'b1;
                                resync_taken <= 1'b1;
                                ext_q        <= '0;
                                shrink_q     <= '0;
                                resync_done  <= 1'b0;
                                t1_q         <= t1_fix;
                                t2_q         <= t2_fix;
                                sjw_q        <= sjw_fix;
                            end else if (t2_done) begin
                                state        <= SEG_SYNC;
                                cnt          <= '0;
                                bit_end      <= 1'b1;
                                resync_taken <= resync_ok;
                                ext_q        <= '0;
                                shrink_q     <= '0;
                                t1_q         <= t1_fix;
                                t2_q         <= t2_fix;
                                sjw_q        <= sjw_fix;
                            end else begin
                                cnt <= cnt_inc;
                                if (resync_ok) begin
                                    shrink_q     <= sjw_q;
                                    resync_done  <= 1'b1;
                                    resync_taken <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state <= SEG_SYNC;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign counto = cnt[WIDTH-1:0];
    assign seg    = state;

endmodule

// File: tb/tb_bittime_counter.sv
// Directed-vector bench for bittime_counter: each step drives one cycle and
// compares {seg, counto, sample_point, bit_end, resync_taken} to a hand value.
module tb_bittime_counter;

    localparam int unsigned W = 4;
    localparam logic [1:0] SY = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;

    logic         clock = 1'b0;
    logic         reset;
    logic         Prescale_EN;
    logic [W-1:0] tseg1;
    logic [W-1:0] tseg2;
    logic [W-1:0] sjw;
    logic         hard_sync;
    logic         rx_edge;
    logic [W-1:0] counto;
    logic [1:0]   seg;
    logic         sample_point;
    logic         bit_end;
    logic         resync_taken;

    int n_cmp = 0;
    int n_bad = 0;

    bittime_counter #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .Prescale_EN  (Prescale_EN),
        .tseg1        (tseg1),
        .tseg2        (tseg2),
        .sjw          (sjw),
        .hard_sync    (hard_sync),
        .rx_edge      (rx_edge),
        .counto       (counto),
        .seg          (seg),
        .sample_point (sample_point),
        .bit_end      (bit_end),
        .resync_taken (resync_taken)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %03h expected %03h (seg,counto,sp,be,rt)", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] pack(input logic [1:0] s, input int c,
                                         input logic sp, input logic be, input logic rt);
        return 32'({s, W'(c), sp, be, rt});
    endfunction

    function automatic logic [31:0] observed();
        return 32'({seg, counto, sample_point, bit_end, resync_taken});
    endfunction

    // One clock: drive inputs, take the rising edge, then compare 1 ns later
    task automatic step(input logic en, input logic hs, input logic rx,
                        input logic [1:0] s, input int c,
                        input logic sp, input logic be, input logic rt, input string tag);
        Prescale_EN = en;
        hard_sync   = hs;
        rx_edge     = rx;
        @(posedge clock);
        #1;
        Prescale_EN = 1'b0;
        hard_sync   = 1'b0;
        rx_edge     = 1'b0;
        check(tag, observed(), pack(s, c, sp, be, rt));
    endtask

    initial begin
        reset = 1'b1; Prescale_EN = 1'b0; hard_sync = 1'b0; rx_edge = 1'b0;
        tseg1 = 4'd5; tseg2 = 4'd3; sjw = 4'd1;
        #1;
        check("rst_async", observed(), pack(SY, 0, 0, 0, 0));
        step(1, 1, 1, SY, 0, 0, 0, 0, "rst_hold");
        reset = 1'b0;

        // First bit after reset runs on the 1/1/1 shadow; 5/3/1 latched at SYNC entry
        step(1, 0, 0, T1, 0, 0, 0, 0, "b0_t1");
        step(1, 0, 0, T2, 0, 1, 0, 0, "b0_sp");
        step(1, 0, 0, SY, 0, 0, 1, 0, "b0_end");

        // Nominal 5/3/1 bit: 9 quanta
        step(1, 0, 0, T1, 0, 0, 0, 0, "nom_t1c0");
        step(1, 0, 0, T1, 1, 0, 0, 0, "nom_t1c1");
        step(1, 0, 0, T1, 2, 0, 0, 0, "nom_t1c2");
        step(1, 0, 0, T1, 3, 0, 0, 0, "nom_t1c3");
        step(1, 0, 0, T1, 4, 0, 0, 0, "nom_t1c4");
        step(1, 0, 0, T2, 0, 1, 0, 0, "nom_sp");
        step(1, 0, 0, T2, 1, 0, 0, 0, "nom_t2c1");
        step(1, 0, 0, T2, 2, 0, 0, 0, "nom_t2c2");
        step(1, 0, 0, SY, 0, 0, 1, 0, "nom_end");

        // Positive resync at TSEG1 counto=2, second edge ignored, 10-quantum bit
        step(1, 0, 0, T1, 0, 0, 0, 0, "pos_t1c0");
        step(1, 0, 0, T1, 1, 0, 0, 0, "pos_t1c1");
        step(1, 0, 0, T1, 2, 0, 0, 0, "pos_t1c2");
        step(1, 0, 1, T1, 3, 0, 0, 1, "pos_resync");
        step(1, 0, 1, T1, 4, 0, 0, 0, "pos_2nd_edge");
        step(1, 0, 0, T1, 5, 0, 0, 0, "pos_ext");
        step(1, 0, 0, T2, 0, 1, 0, 0, "pos_sp");
        step(1, 0, 0, T2, 1, 0, 0, 0, "pos_t2c1");
        sjw = 4'd2;
        step(1, 0, 0, T2, 2, 0, 0, 0, "pos_t2c2");
        step(1, 0, 0, SY, 0, 0, 1, 0, "pos_end");

        // Negative resync, T2=3 SJW=2, edge at TSEG2 counto=1 ends the bit early
        step(1, 0, 0, T1, 0, 0, 0, 0, "neg_t1c0");
        step(1, 0, 0, T1, 1, 0, 0, 0, "neg_t1c1");
        step(1, 0, 0, T1, 2, 0, 0, 0, "neg_t1c2");
        step(1, 0, 0, T1, 3, 0, 0, 0, "neg_t1c3");
        step(1, 0, 0, T1, 4, 0, 0, 0, "neg_t1c4");
        step(1, 0, 0, T2, 0, 1, 0, 0, "neg_sp");
        step(1, 0, 0, T2, 1, 0, 0, 0, "neg_t2c1");
        tseg2 = 4'd4; sjw = 4'd1;
        step(1, 0, 1, T1, 0, 0, 1, 1, "neg_early_end");

        // T2=4 SJW=1, edge at TSEG2 counto=0 shrinks TSEG2 to 3 quanta
        step(1, 0, 0, T1, 1, 0, 0, 0, "shr_t1c1");
        step(1, 0, 0, T1, 2, 0, 0, 0, "shr_t1c2");
        step(1, 0, 0, T1, 3, 0, 0, 0, "shr_t1c3");
        step(1, 0, 0, T1, 4, 0, 0, 0, "shr_t1c4");
        step(1, 0, 0, T2, 0, 1, 0, 0, "shr_sp");
        step(1, 0, 1, T2, 1, 0, 0, 1, "shr_resync");
        tseg2 = 4'd3;
        step(1, 0, 0, T2, 2, 0, 0, 0, "shr_t2c2");
        step(1, 0, 0, SY, 0, 0, 1, 0, "shr_end");

        // Hard sync with simultaneous edge in TSEG2; following edge ignored
        step(1, 0, 0, T1, 0, 0, 0, 0, "hs_t1c0");
        step(1, 0, 0, T1, 1, 0, 0, 0, "hs_t1c1");
        step(1, 0, 0, T1, 2, 0, 0, 0, "hs_t1c2");
        step(1, 0, 0, T1, 3, 0, 0, 0, "hs_t1c3");
        step(1, 0, 0, T1, 4, 0, 0, 0, "hs_t1c4");
        step(1, 0, 0, T2, 0, 1, 0, 0, "hs_sp");
        step(1, 0, 0, T2, 1, 0, 0, 0, "hs_t2c1");
        step(1, 1, 1, T1, 0, 0, 0, 0, "hs_apply");
        step(1, 0, 1, T1, 1, 0, 0, 0, "hs_edge_ign");
        step(1, 0, 0, T1, 2, 0, 0, 0, "hs_t1c2b");
        step(1, 0, 0, T1, 3, 0, 0, 0, "hs_t1c3b");
        step(1, 0, 0, T1, 4, 0, 0, 0, "hs_t1c4b");
        step(1, 0, 0, T2, 0, 1, 0, 0, "hs_spb");
        step(1, 0, 0, T2, 1, 0, 0, 0, "hs_t2c1b");
        step(1, 0, 0, T2, 2, 0, 0, 0, "hs_t2c2b");
        step(1, 0, 0, SY, 0, 0, 1, 0, "hs_end");

        // Sparse enables, input events ignored while disabled, tseg1 changed mid-bit
        step(1, 0, 0, T1, 0, 0, 0, 0, "en_t1c0");
        step(0, 1, 1, T1, 0, 0, 0, 0, "en_hold_ign");
        step(0, 0, 0, T1, 0, 0, 0, 0, "en_hold2");
        step(0, 0, 0, T1, 0, 0, 0, 0, "en_hold3");
        step(1, 0, 0, T1, 1, 0, 0, 0, "en_t1c1");
        tseg1 = 4'd2;
        step(1, 0, 0, T1, 2, 0, 0, 0, "mid_t1c2");
        step(1, 0, 0, T1, 3, 0, 0, 0, "mid_t1c3");
        step(1, 0, 0, T1, 4, 0, 0, 0, "mid_t1c4");
        step(1, 0, 0, T2, 0, 1, 0, 0, "mid_old_sp");
        step(0, 0, 0, T2, 0, 0, 0, 0, "mid_sp_drop");
        step(1, 0, 0, T2, 1, 0, 0, 0, "mid_t2c1");
        step(1, 0, 0, T2, 2, 0, 0, 0, "mid_t2c2");
        step(1, 0, 0, SY, 0, 0, 1, 0, "mid_end");
        step(0, 0, 0, SY, 0, 0, 0, 0, "mid_be_drop");
        step(1, 0, 0, T1, 0, 0, 0, 0, "new_t1c0");
        step(1, 0, 0, T1, 1, 0, 0, 0, "new_t1c1");
        step(1, 0, 0, T2, 0, 1, 0, 0, "new_sp");
        step(1, 0, 0, T2, 1, 0, 0, 0, "new_t2c1");
        step(1, 0, 0, T2, 2, 0, 0, 0, "new_t2c2");
        step(1, 0, 0, SY, 0, 0, 1, 0, "new_end");
        step(1, 0, 0, T1, 0, 0, 0, 0, "rst_pre");

        // Asynchronous reset mid-TSEG1, back to the 1/1/1 shadow
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_async", observed(), pack(SY, 0, 0, 0, 0));
        step(1, 0, 0, SY, 0, 0, 0, 0, "rst_mid_hold");
        reset = 1'b0;
        tseg1 = 4'd0;
        step(0, 0, 0, SY, 0, 0, 0, 0, "rel_idle");
        step(1, 0, 0, T1, 0, 0, 0, 0, "rel_leave_sync");
        step(1, 0, 0, T2, 0, 1, 0, 0, "rel_sp");
        step(1, 0, 0, SY, 0, 0, 1, 0, "rel_end");

        // tseg1=0 behaves as one quantum
        step(1, 0, 0, T1, 0, 0, 0, 0, "z_t1c0");
        step(1, 0, 0, T2, 0, 1, 0, 0, "z_sp");
        step(1, 0, 0, T2, 1, 0, 0, 0, "z_t2c1");
        step(1, 0, 0, T2, 2, 0, 0, 0, "z_t2c2");
        step(1, 0, 0, SY, 0, 0, 1, 0, "z_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bittime_counter.md
# bittime_counter

Parametrised bit-timing quantum counter for the CAN controller core; successor to the fixed 4-bit time-quantum counter.
- Counts time quanta on each prescaler enable and sequences one bit through the segments SYNC, TSEG1 and TSEG2.
- Applies hard synchronisation and SJW-limited resynchronisation on incoming edges.
- Issues a sample-point pulse and a bit-end pulse to the bit-stream FSM.
- Sits between the prescaler and the receive/transmit bit FSM.

## Interface
- WIDTH, 4: width of counto and of the segment configuration fields; legal range 3..8.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- Prescale_EN  in  1  time-quantum enable from the prescaler. All state advances only in cycles where this is 1.
- tseg1  in  WIDTH  TSEG1 length in quanta (prop + phase1). The value 0 is treated as 1.
- tseg2  in  WIDTH  TSEG2 length in quanta (phase2). The value 0 is treated as 1.
- sjw  in  WIDTH  synchronisation jump width. The value 0 is treated as 1. It is clamped to the latched tseg2.
- hard_sync  in  1  hard-synchronisation request from the FSM (bus idle / start of frame).
- rx_edge  in  1  recessive-to-dominant edge pulse from the edge detector. Sampled only when Prescale_EN=1.
- counto  out  WIDTH  quantum index within the current segment, starting at 0.
- seg  out  2  current segment: 00 SYNC, 01 TSEG1, 10 TSEG2. The value 11 is never produced.
- sample_point  out  1  one-clock pulse marking the end of TSEG1.
- bit_end  out  1  one-clock pulse marking the end of TSEG2 or an early bit end.
- resync_taken  out  1  one-clock pulse when a resynchronisation is applied.

## Operation
- Reset values: seg=SYNC, counto=0, all pulses 0, extension and shrink registers 0, resync_done=0, shadow configuration = 1/1/1.
- Configuration latch:
  - tseg1, tseg2 and sjw (zero-fixed and clamped) are latched into shadow registers on every entry into SYNC and on every hard sync.
  - Changes mid-bit take effect at the next bit only.
- Event priority within an enabled cycle: reset > hard_sync > rx_edge resync > normal count.
- Hard sync (any segment):
  - next state is TSEG1 with counto=0;
  - ext and shrink are cleared;
  - resync_done=1, so no further resync is allowed in this bit;
  - no bit_end pulse is issued.
- SYNC: lasts 1 quantum, then goes to TSEG1 with counto=0 and resync_done=0. An rx_edge in SYNC is ignored (phase error 0).
- TSEG1: counto increments each quantum.
  - End condition: counto == T1-1+ext. Then go to TSEG2 with counto=0 and pulse sample_point.
  - Positive resync: rx_edge at counto=c while resync_done=0 sets ext = min(c+1, SJW), sets resync_done=1 and pulses resync_taken.
  - The end compare uses WIDTH+1 bits, so it cannot overflow.
- TSEG2: counto increments each quantum.
  - End condition: counto == T2-1-shrink. Then go to SYNC with counto=0, pulse bit_end, and clear ext and shrink.
  - Negative resync: rx_edge at counto=c while resync_done=0 computes e = T2-c.
    - If e <= SJW: the edge quantum becomes the SYNC of the next bit. Next state is TSEG1 with counto=0; bit_end and resync_taken pulse; the configuration is latched.
    - Otherwise: shrink = SJW, resync_done=1, resync_taken pulses. The end compare then uses the reduced length.
- counto never wraps: segment lengths are bounded by 2^WIDTH-1 plus SJW, and counto stays below 2^WIDTH-1+SJW only in the extended TSEG1. counto is therefore WIDTH+1 bits internally; the output shows the low WIDTH bits.
- Prescale_EN=0 holds all state; rx_edge and hard_sync are ignored in such cycles.

## Timing
- Registered outputs:
  - counto and seg update on the rising edge of an enabled cycle.
  - The pulses are high for exactly the one clock following that edge, then return to 0 even if Prescale_EN stays 0.
- Nominal bit length is 1+T1+T2 quanta; sample_point falls after 1+T1(+ext) quanta.
- Reset asserted mid-bit returns every output to its reset value asynchronously. The first enabled cycle after release leaves SYNC.
- Simultaneous hard_sync and rx_edge: only the hard sync is applied and resync_taken stays 0.

## Test plan
- T1=5, T2=3, SJW=1, no edges, Prescale_EN every cycle -> seg sequence SYNC, 5×TSEG1, 3×TSEG2. sample_point 6 clocks after SYNC entry, bit_end every 9 clocks.
- Same config, rx_edge at TSEG1 counto=2 -> resync_taken, TSEG1 lasts 6 quanta, bit is 10 quanta. A second edge in the same bit is ignored.
- T2=3, SJW=2, rx_edge at TSEG2 counto=1 -> next state TSEG1 counto=0, bit_end and resync_taken pulse, bit length 1+5+2-1 = 7 quanta.
- T2=4, SJW=1, rx_edge at TSEG2 counto=0 -> TSEG2 lasts 3 quanta, bit length 9.
- hard_sync in TSEG2 counto=1 together with rx_edge -> TSEG1 counto=0, no bit_end, no resync_taken. A following edge in TSEG1 is ignored.
- Prescale_EN toggled 1-in-4, reset pulsed mid-TSEG1, tseg1 changed mid-bit -> counts advance only on enabled cycles, reset forces SYNC/0 immediately, the new tseg1 is used only from the next SYNC.
